// File: rtl/pmem_loader_if.sv
// pmem_loader_if: byte-stream input and program-memory write port of the loader
interface pmem_loader_if;
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic load_en;
  logic [7:0] load_addr;
  logic [11:0] load_instr;
  logic load_done;
  logic busy;
  logic err;
  modport master (
    output start, in_data, in_valid,
    input in_ready, load_en, load_addr, load_instr, load_done, busy, err
  );
  modport slave (
    input start, in_data, in_valid,
    output in_ready, load_en, load_addr, load_instr, load_done, busy, err
  );
endinterface

// File: rtl/pmem_loader.sv
// pmem_loader: assembles byte pairs into 12-bit words and writes DEPTH of them to program memory; PMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module pmem_loader #(
  parameter int DEPTH = 10
) (
  input logic clk,
  input logic rst,
  pmem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, HI, LO, WRITE, DONE
`ifdef PMEM_LOADER_CHECKSUM_EN
    , CSUM, ERR
`endif
  } state_t;
  state_t st, nxt;
  logic [7:0] addr, lo;
  logic [3:0] hi;
  logic rdy, xfer, last;
`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif
  // state register; reset abandons any partial load immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nxt;
  end
  // next state and state-decoded outputs; start is only honoured when not busy
  always_comb begin
    nxt = st;
    rdy = st == HI || st == LO
`ifdef PMEM_LOADER_CHECKSUM_EN
      || st == CSUM
`endif
      ;
    xfer = rdy && bus.in_valid;
    last = addr == 8'(DEPTH - 1);
    bus.in_ready = rdy;
    bus.busy = rdy || st == WRITE;
    bus.load_en = st == WRITE;
    bus.load_done = st == DONE;
    bus.load_addr = addr;
    bus.load_instr = {hi, lo};
`ifdef PMEM_LOADER_CHECKSUM_EN
    bus.err = st == ERR;
`else
    bus.err = 1'b0;
`endif
    case (st)
      HI: nxt = xfer ? LO : HI;
      LO: nxt = xfer ? WRITE : LO;
`ifdef PMEM_LOADER_CHECKSUM_EN
      WRITE: nxt = last ? CSUM : HI;
      CSUM: if (xfer) nxt = bus.in_data == sum ? DONE : ERR;
`else
      WRITE: nxt = last ? DONE : HI;
`endif
      default: if (bus.start) nxt = HI;
    endcase
  end
  // word assembly, address counter and running byte sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      hi <= '0;
      lo <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      if (bus.start && !bus.busy) addr <= '0;
      if (xfer && st == HI) hi <= bus.in_data[3:0];
      if (xfer && st == LO) lo <= bus.in_data;
      if (st == WRITE && !last) addr <= addr + 8'd1;
`ifdef PMEM_LOADER_CHECKSUM_EN
      if (bus.start && !bus.busy) sum <= '0;
      else if (xfer && (st == HI || st == LO)) sum <= sum + bus.in_data;
`endif
    end
  end
endmodule
